div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_pkg.sv | 14 +
 rtl/div_step.sv | 36 +++
 rtl/div_iter.sv | 144 ++++++++++++++
 tb/tb_div_iter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared definitions for the iterative divider.
//   - div_state_e : FSM state encoding (idle, run, done)
//   - DivWidth    : default operand / quotient width
package div_iter_pkg;

    localparam int unsigned DivWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports:
//   rem_i     - partial remainder before this step
//   q_i       - quotient shift register (holds the unconsumed dividend bits)
//   divisor_i - unsigned divisor magnitude
//   rem_o     - partial remainder after this step
//   q_o       - quotient shift register after this step (new quotient bit in LSB)
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        // Shift {rem, q} left by one; the extra bit keeps the full magnitude
        // when the divisor is as large as 2^(WIDTH-1) or more.
        rem_sh = {rem_i, q_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor_i};
        if (trial[WIDTH]) begin
            // Negative trial: restore; rem_sh < divisor so it fits in WIDTH bits.
            rem_o = rem_sh[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = trial[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// div_iter: multi-cycle signed integer divider (restoring, one bit per cycle).
// Quotient truncates toward zero; remainder stays internal.
// Ports:
//   clock          - rising-edge clock
//   reset          - asynchronous active-high reset
//   ctrl_DIV       - start pulse, honoured only while idle
//   data_operandA  - signed dividend, captured on start
//   data_operandB  - signed divisor, captured on start
//   data_result    - signed quotient, held until the next completion
//   data_exception - divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY - one-cycle completion pulse
//   busy           - high from the cycle after start through the done pulse
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth,
    // Must be wide enough to hold WIDTH.
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             sign_q, sign_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem, step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (rem_q),
        .q_i       (q_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        // Most-negative value negates to itself, which is the correct unsigned magnitude.
        a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        q_d       = q_q;
        divisor_d = divisor_q;
        sign_d    = sign_q;
        dz_d      = dz_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        busy_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ctrl_DIV) begin
                    q_d       = a_mag;
                    divisor_d = b_mag;
                    sign_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    rem_d     = '0;
                    cnt_d     = '0;
                    dz_d      = (data_operandB == '0);
                    busy_d    = 1'b1;
                    state_d   = (data_operandB == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                rem_d  = step_rem;
                q_d    = step_q;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Two's-complement wrap makes MIN / -1 return MIN.
                result_d = dz_q ? '0 : (sign_q ? -q_q : q_q);
                exc_d    = dz_q;
                rdy_d    = 1'b1;
                busy_d   = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            divisor_q <= '0;
            sign_q    <= 1'b0;
            dz_q      <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            divisor_q <= divisor_d;
            sign_q    <= sign_d;
            dz_q      <= dz_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed-vector bench for div_iter (WIDTH = 32).
// Cycle N is the interval just after the Nth rising edge, the start edge being 0.
module tb_div_iter;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_iter #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts a division on the next edge (cycle 0), optionally pulses ctrl_DIV
    // again at edge dup_at with other operands, then checks latency and result.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] exp_res,
                           input logic exp_exc, input int dup_at);
        int lat;
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        check_eq({tag, "_busy0"}, 32'(busy), 32'd1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == dup_at) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd999;
                data_operandB = 32'd3;
            end
            @(posedge clock);
            #1;
            ctrl_DIV = 1'b0;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, data_result, exp_res);
        check_eq({tag, "_exc"}, 32'(data_exception), 32'(exp_exc));
        @(posedge clock);
        #1;
        check_eq({tag, "_rdy_off"}, 32'(data_resultRDY), 32'd0);
        check_eq({tag, "_busy_off"}, 32'(busy), 32'd0);
        check_eq({tag, "_hold"}, data_result, exp_res);
        check_eq({tag, "_hold_exc"}, 32'(data_exception), 32'(exp_exc));
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #1;
        check_eq("rst_res", data_result, 32'd0);
        check_eq("rst_exc", 32'(data_exception), 32'd0);
        check_eq("rst_rdy", 32'(data_resultRDY), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // First edge after reset release is the start edge.
        run_div("pos_pos", 32'd100, 32'd7, 33, 32'd14, 1'b0, 0);
        run_div("neg_pos", -32'sd100, 32'd7, 33, 32'hFFFF_FFF2, 1'b0, 0);
        run_div("pos_neg", 32'd100, -32'sd7, 33, 32'hFFFF_FFF2, 1'b0, 0);
        run_div("neg_neg", -32'sd100, -32'sd7, 33, 32'd14, 1'b0, 0);
        run_div("div_zero", 32'd5, 32'd0, 1, 32'd0, 1'b1, 0);
        run_div("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b0, 0);
        run_div("small", 32'd7, 32'd100, 33, 32'd0, 1'b0, 0);
        run_div("max_1", 32'h7FFF_FFFF, 32'd1, 33, 32'h7FFF_FFFF, 1'b0, 0);
        run_div("min_min", 32'h8000_0000, 32'h8000_0000, 33, 32'd1, 1'b0, 0);
        run_div("ignore2", 32'd100, 32'd7, 33, 32'd14, 1'b0, 10);

        // Abort mid-run: start at edge 0, assert reset just after edge 12.
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (12) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_rdy", 32'(data_resultRDY), 32'd0);
        check_eq("abort_res", data_result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("abort_idle", 32'(busy), 32'd0);
        // Starts at edge 14; a leftover pulse from the aborted op would shorten the latency.
        run_div("after_rst", -32'sd1000, 32'd3, 33, 32'hFFFF_FEB3, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
